clk_div_multi: RTL and testbench

- Parametrised successor to the single free-running power-of-two divider.
- Generates NCH independent clock-enable ticks and 50%-duty toggle outputs from the 125 MHz clk_in.
- Divisors are runtime-programmable to any integer value, not limited to powers of two. Divisor changes are glitch-free.
- Feeds reel-spin timing, display scan and debounce sampling in the slot machine. Downstream logic uses tick as a clock enable on clk_in, never as a clock.

---
 rtl/clk_div_multi.sv | 89 ++++++++
 tb/tb_clk_div_multi.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH programmable clock-enable dividers; optional CLK_DIV_MULTI_PHASE_SYNC_EN adds sync input
module clk_div_multi #(
    parameter int NCH     = 2,
    parameter int W       = 27,
    parameter int DEF_DIV = 125000000
) (
    input  logic             clk_in,
    input  logic             rst_n,
`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
    input  logic             sync,
`endif
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   load,
    input  logic [NCH*W-1:0] div_val,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   busy
);
    localparam logic [W-1:0] DEF = W'(DEF_DIV);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
        logic         tick_q, tick_d, clk_q, clk_d, busy_q, busy_d;
        logic [W-1:0] val, eff, eff_new;
        logic         term;
        assign val     = div_val[i*W +: W];
        assign eff     = (act_q < W'(2)) ? W'(1) : act_q;
        assign eff_new = (val < W'(2)) ? W'(1) : val;
        assign term    = cnt_q == eff - W'(1);
        // next state: period boundary swaps in pending divisor; idle loads apply directly
        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            clk_d  = clk_q;
            busy_d = busy_q;
            if (en[i]) begin
                if (term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    clk_d  = ~clk_q;
                    act_d  = load[i] ? val : pend_q;
                    pend_d = act_d;
                    busy_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q + W'(1);
                    pend_d = load[i] ? val : pend_q;
                    busy_d = load[i] | busy_q;
                end
            end else if (load[i]) begin
                act_d  = val;
                pend_d = val;
                busy_d = 1'b0;
                cnt_d  = (cnt_q >= eff_new) ? '0 : cnt_q;
            end
`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
            if (sync) begin
                cnt_d  = '0;
                tick_d = 1'b0;
                clk_d  = 1'b0;
                act_d  = load[i] ? val : pend_q;
                pend_d = act_d;
                busy_d = 1'b0;
            end
`endif
        end
        // channel state registers
        always_ff @(posedge clk_in) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                act_q  <= DEF;
                pend_q <= DEF;
                tick_q <= 1'b0;
                clk_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                clk_q  <= clk_d;
                busy_q <= busy_d;
            end
        end
        assign tick[i]    = tick_q;
        assign clk_out[i] = clk_q;
        assign busy[i]    = busy_q;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized check of clk_div_multi against a countdown reference model
module tb_clk_div_multi;
    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int DEF = 4;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sync;
    logic [NCH-1:0]   en, load, tick, clk_out, busy;
    logic [NCH*W-1:0] div_val;
    int               n_cmp = 0, n_bad = 0;
    bit               chk_on = 1'b0;

    always #5 clk_in = ~clk_in;

    clk_div_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
        .sync    (sync),
`endif
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .tick    (tick),
        .clk_out (clk_out),
        .busy    (busy)
    );

    // model: cycles left until the next tick, raw divisors, and expected outputs
    int m_left[NCH], m_act[NCH], m_pend[NCH];
    bit m_tick[NCH], m_clk[NCH], m_busy[NCH];

    function automatic int effv(input int v);
        return (v < 2) ? 1 : v;
    endfunction

    always @(posedge clk_in) begin
        for (int c = 0; c < NCH; c++) begin
            int v, pos;
            bit do_sync;
            v = int'(div_val[c*W +: W]);
            do_sync = 1'b0;
`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
            do_sync = sync;
`endif
            if (!rst_n) begin
                m_act[c] = DEF; m_pend[c] = DEF; m_left[c] = effv(DEF);
                m_tick[c] = 0; m_clk[c] = 0; m_busy[c] = 0;
            end else if (do_sync) begin
                m_act[c] = load[c] ? v : m_pend[c];
                m_pend[c] = m_act[c];
                m_left[c] = effv(m_act[c]);
                m_tick[c] = 0; m_clk[c] = 0; m_busy[c] = 0;
            end else if (en[c]) begin
                m_tick[c] = (m_left[c] == 1);
                if (m_tick[c]) begin
                    m_clk[c] = !m_clk[c];
                    m_act[c] = load[c] ? v : m_pend[c];
                    m_pend[c] = m_act[c];
                    m_busy[c] = 0;
                    m_left[c] = effv(m_act[c]);
                end else begin
                    m_left[c]--;
                    if (load[c]) begin m_pend[c] = v; m_busy[c] = 1; end
                end
            end else begin
                m_tick[c] = 0;
                if (load[c]) begin
                    pos = effv(m_act[c]) - m_left[c];
                    m_act[c] = v; m_pend[c] = v; m_busy[c] = 0;
                    if (pos >= effv(v)) pos = 0;
                    m_left[c] = effv(v) - pos;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            for (int c = 0; c < NCH; c++) begin
                n_cmp += 3;
                if (tick[c] !== m_tick[c]) begin
                    n_bad++;
                    $display("FAIL model_tick ch%0d t=%0t got=%b exp=%b", c, $time, tick[c], m_tick[c]);
                end
                if (clk_out[c] !== m_clk[c]) begin
                    n_bad++;
                    $display("FAIL model_clk_out ch%0d t=%0t got=%b exp=%b", c, $time, clk_out[c], m_clk[c]);
                end
                if (busy[c] !== m_busy[c]) begin
                    n_bad++;
                    $display("FAIL model_busy ch%0d t=%0t got=%b exp=%b", c, $time, busy[c], m_busy[c]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick_wait(input int c, output int n);
        n = 0;
        do begin
            @(posedge clk_in); #1; n++;
        end while (!tick[c] && n < 64);
    endtask

    task automatic step;
        @(posedge clk_in); #1;
    endtask

    initial begin
        int n;
        bit prev;
        rst_n = 0; sync = 0; en = '0; load = '0; div_val = '0;
        step(); chk_on = 1;
        step(); step();
        chk("reset_tick", int'(tick), 0);
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1; en = '1;
        tick_wait(0, n); chk("first_tick", n, 4);
        chk("clk_out_high", int'(clk_out[0]), 1);
        tick_wait(0, n); chk("tick_gap4", n, 4);
        chk("clk_out_low", int'(clk_out[0]), 0);
        load[0] = 1; div_val[0 +: W] = 5; step(); load = '0;
        chk("busy_after_load", int'(busy[0]), 1);
        tick_wait(0, n); chk("old_div_completes", n, 3);
        chk("busy_cleared", int'(busy[0]), 0);
        tick_wait(0, n); chk("tick_gap5", n, 5);
        step();
        load[0] = 1; div_val[0 +: W] = 3; step(); load = '0;
        chk("busy_load3", int'(busy[0]), 1);
        tick_wait(0, n); chk("div5_finishes", n, 3);
        tick_wait(0, n); chk("tick_gap3", n, 3);
        load[0] = 1; div_val[0 +: W] = 0; step(); load = '0;
        tick_wait(0, n); chk("div0_boundary", n, 2);
        for (int k = 0; k < 4; k++) begin
            prev = clk_out[0];
            step();
            chk("div0_tick_high", int'(tick[0]), 1);
            chk("div0_clk_toggle", int'(clk_out[0] != prev), 1);
        end
        load[0] = 1; div_val[0 +: W] = 6; step(); load = '0;
        step(); step();
        en[0] = 0; prev = clk_out[0];
        repeat (10) step();
        chk("en_low_tick", int'(tick[0]), 0);
        chk("en_low_clk_hold", int'(clk_out[0]), int'(prev));
        en[0] = 1;
        tick_wait(0, n); chk("resume_tick", n, 4);
        repeat (3000) begin
            @(posedge clk_in); #1;
            rst_n = ($urandom % 300) != 0;
            sync = ($urandom % 150) == 0;
            for (int c = 0; c < NCH; c++) begin
                en[c] = ($urandom % 4) != 0;
                load[c] = ($urandom % 10) == 0;
                div_val[c*W +: W] = 8'($urandom_range(0, 12));
            end
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
